line_clear_sequencer: RTL and testbench
=======================================

Name: line_clear_sequencer

Overview:
- Sequences the VGA playfield display path during row clears: freezes the displayed 10x20 matrix, blinks the full rows through the `flash` mask frame-synchronously, then collapses the rows and hands the result back to game logic.
- Sits between game logic (objectMatrix producer) and VGAdisplay (objectMatrix/flash consumer).
- Owns tear-free display updates: the display matrix changes only on frame boundaries.

Parameters:
- FLASH_FRAMES, 8, frames per ON phase and per OFF phase; legal range 1-255.
- FLASH_BLINKS, 3, ON/OFF pairs per clear; legal range 1-15.

Ports:
- clk  in  1  pixel clock (25 MHz).
- clr  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank, from VGA timing.
- start  in  1  request a clear pass on matrix_in; sampled only in IDLE.
- matrix_in  in  200  live playfield; bit row*10+col, row 0 = top, row 19 = bottom.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when matrix_out is valid.
- lines_cleared  out  3  number of full rows removed (0-4), valid with done and held.
- matrix_out  out  200  collapsed matrix, held until the next accepted start.
- matrix_disp  out  200  to VGAdisplay objectMatrix.
- flash  out  200  to VGAdisplay flash.

Behaviour:
- Reset (clr=1 at a clock edge): state=IDLE; busy, done, lines_cleared, matrix_out, matrix_disp and flash are all 0; counters are 0. Reset wins over every other input and aborts any pass in progress.
- Snapshot: on an accepted start, snap<=matrix_in. full_mask is combinational from snap: a row's 10 bits are all set to 1 when that row is complete, otherwise 0. nfull is popcount of the full rows, 0-4.
- FSM states: IDLE, WAIT_FRAME, FLASH_ON, FLASH_OFF, COLLAPSE, DONE.
- IDLE:
  - On frame_start, matrix_disp<=matrix_in.
  - If start=1, latch snap and go to WAIT_FRAME. A frame_start in the same cycle still updates matrix_disp but does not count as the sync frame.
- WAIT_FRAME:
  - If nfull=0, go straight to COLLAPSE.
  - Otherwise wait for frame_start, then go to FLASH_ON with frame_cnt=0 and blink_cnt=0.
  - matrix_disp<=snap on entry, then frozen.
- FLASH_ON:
  - flash=full_mask (registered).
  - Each frame_start increments frame_cnt. At frame_cnt==FLASH_FRAMES-1 with frame_start, go to FLASH_OFF and clear frame_cnt.
- FLASH_OFF:
  - flash=0.
  - At FLASH_FRAMES frame_starts, increment blink_cnt.
  - If blink_cnt==FLASH_BLINKS-1, go to COLLAPSE; otherwise go back to FLASH_ON.
- COLLAPSE: exactly 20 cycles.
  - rd scans rows 19 down to 0, one per cycle. wr starts at 19.
  - A non-full row rd is copied to row wr of the work buffer, then wr decrements. Full rows are skipped.
  - Rows 0 to wr that remain after the scan are zero.
  - Work buffer is cleared on entry.
- DONE (one cycle):
  - done=1, matrix_out<=work, matrix_disp<=work, lines_cleared<=nfull.
  - Next state IDLE.
  - busy falls in the same cycle done rises.
- Latency:
  - With nfull=0: start -> done = 22 cycles (WAIT_FRAME 1, COLLAPSE 20, DONE 1).
  - With nfull>0: frame-sync wait + 2*FLASH_FRAMES*FLASH_BLINKS frames + 21 cycles.
- start while busy is ignored, with no queueing. matrix_in changes while busy are ignored.
- Non-contiguous full rows, e.g. rows 17 and 19: both are removed and the gap row shifts down correctly.
- Four full rows (max) gives lines_cleared=4.
- Row 0 full is removed; the top is zero-filled.

Decomposition:
- Shared package `tetris_pkg`:
  - constants COLS=10, ROWS=20, CELLS=200;
  - state enum;
  - row-index helper function for base bit row*COLS.
- Sub-module row_compactor: the COLLAPSE datapath (rd/wr counters, work buffer, row copy), started and stopped by the FSM.
- The top level keeps the FSM, frame counters, snapshot and output registers.

Test Plan:
- Reset mid-FLASH_ON (clr=1 for 1 cycle) -> next cycle flash=0, matrix_disp=0, busy=0; a later start behaves normally.
- matrix_in with no full rows, start -> done 22 cycles later, lines_cleared=0, matrix_out==matrix_in, flash never nonzero.
- Row 19 full plus cell (18,3) set, FLASH_FRAMES=2, FLASH_BLINKS=1:
  - flash bits 190-199 =1 for exactly 2 frame_starts, then 0 for 2;
  - done with lines_cleared=1, matrix_out has only bit 193 set.
- Rows 16, 18, 19 full and row 17 = 0x155 pattern -> lines_cleared=3, row 19 of matrix_out = row 17 pattern, rows 0-18 zero.
- start asserted in the same cycle as frame_start -> that frame_start is not counted; flash rises only after the next frame_start. A second start while busy has no effect.
- IDLE with matrix_in changing mid-frame -> matrix_disp updates only on frame_start cycles.

Source files
------------

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Playfield geometry, sequencer state encoding, row indexing.
// Revision    : 1.0
// ============================================================================
package tetris_pkg;

    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int CELLS = 200;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_FLASH_ON   = 3'd2,
        S_FLASH_OFF  = 3'd3,
        S_COLLAPSE   = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    // Bit index of column 0 of the given row.
    function automatic logic [7:0] row_base(input logic [4:0] row);
        return 8'(row) * 8'(COLS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_compactor.sv
`default_nettype none
// ============================================================================
// Module      : row_compactor
// Description : Bottom-up row compaction, one source row per cycle.
// Revision    : 1.0
// ============================================================================
module row_compactor
    import tetris_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             i_load,
    input  logic             i_run,
    input  logic [CELLS-1:0] i_src,
    input  logic [ROWS-1:0]  i_full_rows,
    output logic             o_last,
    output logic [CELLS-1:0] o_result
);

    logic [CELLS-1:0] r_work;
    logic [4:0]       r_rd;
    logic [4:0]       r_wr;
    logic             w_keep;

    // o_result already contains the row being copied this cycle, so the
    // caller can capture the finished buffer on the same edge as o_last.
    always_comb begin
        w_keep   = i_run && !i_full_rows[r_rd];
        o_result = r_work;
        if (w_keep) begin
            o_result[row_base(r_wr) +: COLS] = i_src[row_base(r_rd) +: COLS];
        end
    end

    assign o_last = (r_rd == 5'd0);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_work <= '0;
            r_rd   <= '0;
            r_wr   <= '0;
        end else if (i_load) begin
            r_work <= '0;
            r_rd   <= 5'(ROWS - 1);
            r_wr   <= 5'(ROWS - 1);
        end else if (i_run) begin
            r_work <= o_result;
            r_rd   <= r_rd - 5'd1;
            if (w_keep) begin
                r_wr <= r_wr - 5'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_sequencer
// Description : Freezes, blinks and collapses full playfield rows, updating
//               the displayed matrix only on frame boundaries.
// Revision    : 1.0
// ============================================================================
module line_clear_sequencer
    import tetris_pkg::*;
#(
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_BLINKS = 3
)(
    input  logic             clk,
    input  logic             clr,
    input  logic             frame_start,
    input  logic             start,
    input  logic [CELLS-1:0] matrix_in,
    output logic             busy,
    output logic             done,
    output logic [2:0]       lines_cleared,
    output logic [CELLS-1:0] matrix_out,
    output logic [CELLS-1:0] matrix_disp,
    output logic [CELLS-1:0] flash
);

    localparam logic [7:0] c_frame_last = 8'(FLASH_FRAMES - 1);
    localparam logic [3:0] c_blink_last = 4'(FLASH_BLINKS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CELLS-1:0] r_snap;
    logic [7:0]       r_frame_cnt;
    logic [3:0]       r_blink_cnt;
    logic [ROWS-1:0]  w_full_rows;
    logic [CELLS-1:0] w_full_mask;
    logic [4:0]       w_nfull;
    logic             w_frame_wrap;
    logic             w_cmp_load;
    logic             w_cmp_run;
    logic             w_cmp_last;
    logic [CELLS-1:0] w_cmp_result;

    for (genvar r = 0; r < ROWS; r++) begin : g_rows
        assign w_full_rows[r]                = &r_snap[r*COLS +: COLS];
        assign w_full_mask[r*COLS +: COLS]   = {COLS{w_full_rows[r]}};
    end

    always_comb begin
        w_nfull = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_nfull = w_nfull + 5'(w_full_rows[r]);
        end
    end

    assign w_frame_wrap = frame_start && (r_frame_cnt == c_frame_last);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_WAIT_FRAME;
            end
            S_WAIT_FRAME: begin
                if (w_nfull == 5'd0)  w_next_state = S_COLLAPSE;
                else if (frame_start) w_next_state = S_FLASH_ON;
            end
            S_FLASH_ON: begin
                if (w_frame_wrap) w_next_state = S_FLASH_OFF;
            end
            S_FLASH_OFF: begin
                if (w_frame_wrap) begin
                    w_next_state = (r_blink_cnt == c_blink_last) ? S_COLLAPSE : S_FLASH_ON;
                end
            end
            S_COLLAPSE: begin
                if (w_cmp_last) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state == S_WAIT_FRAME) || (r_state == S_FLASH_ON) ||
                     (r_state == S_FLASH_OFF)  || (r_state == S_COLLAPSE);
        done       = (r_state == S_DONE);
        w_cmp_run  = (r_state == S_COLLAPSE);
        w_cmp_load = (r_state != S_COLLAPSE) && (w_next_state == S_COLLAPSE);
    end

    // Results are captured on the edge into DONE so they are valid with done.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_snap        <= '0;
            r_frame_cnt   <= '0;
            r_blink_cnt   <= '0;
            matrix_disp   <= '0;
            matrix_out    <= '0;
            lines_cleared <= '0;
            flash         <= '0;
        end else begin
            flash <= (w_next_state == S_FLASH_ON) ? w_full_mask : '0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start || start) matrix_disp <= matrix_in;
                    if (start)                r_snap      <= matrix_in;
                end
                S_WAIT_FRAME: begin
                    r_frame_cnt <= '0;
                    r_blink_cnt <= '0;
                end
                S_FLASH_ON: begin
                    if (frame_start) begin
                        r_frame_cnt <= w_frame_wrap ? 8'd0 : r_frame_cnt + 8'd1;
                    end
                end
                S_FLASH_OFF: begin
                    if (frame_start) begin
                        r_frame_cnt <= w_frame_wrap ? 8'd0 : r_frame_cnt + 8'd1;
                        if (w_frame_wrap) r_blink_cnt <= r_blink_cnt + 4'd1;
                    end
                end
                S_COLLAPSE: begin
                    if (w_cmp_last) begin
                        matrix_out    <= w_cmp_result;
                        matrix_disp   <= w_cmp_result;
                        lines_cleared <= 3'(w_nfull);
                    end
                end
                default: ;
            endcase
        end
    end

    row_compactor u_row_compactor (
        .clk         (clk),
        .clr         (clr),
        .i_load      (w_cmp_load),
        .i_run       (w_cmp_run),
        .i_src       (r_snap),
        .i_full_rows (w_full_rows),
        .o_last      (w_cmp_last),
        .o_result    (w_cmp_result)
    );

endmodule
`default_nettype wire

// File: tb/tb_line_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_clear_sequencer
// Description : Self-checking bench for line_clear_sequencer.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_line_clear_sequencer;

    localparam int FF          = 2;
    localparam int FB          = 1;
    localparam int FS_PER_PASS = 1 + 2 * FF * FB;
    localparam int FRAME_GAP   = 7;

    logic         clk = 1'b0;
    logic         clr;
    logic         frame_start;
    logic         start;
    logic [199:0] matrix_in;
    logic         busy;
    logic         done;
    logic [2:0]   lines_cleared;
    logic [199:0] matrix_out;
    logic [199:0] matrix_disp;
    logic [199:0] flash;

    typedef struct {
        logic [199:0] m;
        logic [2:0]   lines;
        logic [199:0] exp_out;
    } vec_t;

    typedef struct {
        logic [2:0]   lines;
        logic [199:0] out;
    } sb_t;

    vec_t vecs[5];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    line_clear_sequencer #(
        .FLASH_FRAMES (FF),
        .FLASH_BLINKS (FB)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .frame_start   (frame_start),
        .start         (start),
        .matrix_in     (matrix_in),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .matrix_out    (matrix_out),
        .matrix_disp   (matrix_disp),
        .flash         (flash)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [199:0] put_row(input logic [199:0] mm, input int r, input logic [9:0] v);
        mm[r*10 +: 10] = v;
        return mm;
    endfunction

    task automatic run_pass(input logic [199:0] m, input logic [2:0] lines,
                            input logic [199:0] expo, input bit coincide);
        logic [199:0] mask;
        int  nrows;
        int  fs_total, fs_on, fs_bad, early, since_acc, since_fs;
        bit  got;
        sb_t e;
        mask = '0;
        nrows = 0;
        for (int r = 0; r < 20; r++) begin
            if (m[r*10 +: 10] == 10'h3FF) begin
                mask[r*10 +: 10] = 10'h3FF;
                nrows++;
            end
        end
        matrix_in   = m;
        start       = 1'b1;
        frame_start = coincide;
        sb.push_back('{lines: lines, out: expo});
        step();
        start       = 1'b0;
        frame_start = 1'b0;
        check("busy_after_start", {199'd0, busy}, 200'd1);
        check("disp_frozen_snap", matrix_disp, m);
        check("flash_after_start", flash, '0);
        matrix_in = ~m;
        fs_total = 0; fs_on = 0; fs_bad = 0; early = 0;
        since_acc = 0; since_fs = -1; got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            frame_start = (c % FRAME_GAP == FRAME_GAP - 1) && (nrows == 0 || fs_total < FS_PER_PASS);
            start       = (c == 2);
            if (fs_total == 0 && flash != '0) early++;
            if (frame_start) begin
                fs_total++;
                if (mask != '0 && flash == mask) fs_on++;
                else if (flash != '0)            fs_bad++;
            end
            step();
            since_acc++;
            if (frame_start)       since_fs = 0;
            else if (since_fs >= 0) since_fs++;
            frame_start = 1'b0;
            start       = 1'b0;
            if (done) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done");
            if (sb.size() > 0) void'(sb.pop_front());
            clr = 1'b1;
            step();
            clr = 1'b0;
        end else begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=empty required=entry");
            end else begin
                e = sb.pop_front();
                check("lines_cleared", {197'd0, lines_cleared}, {197'd0, e.lines});
                check("matrix_out", matrix_out, e.out);
                check("matrix_disp_done", matrix_disp, e.out);
            end
            check("busy_with_done", {199'd0, busy}, '0);
            check("early_flash", 200'(early), '0);
            check("bad_flash", 200'(fs_bad), '0);
            if (nrows == 0) begin
                check("latency_nofull", 200'(since_acc), 200'd21);
                check("flash_on_frames", 200'(fs_on), '0);
            end else begin
                check("latency_collapse", 200'(since_fs), 200'd20);
                check("flash_on_frames", 200'(fs_on), 200'(FF * FB));
                check("frames_used", 200'(fs_total), 200'(FS_PER_PASS));
            end
            step();
            check("done_pulse", {199'd0, done}, '0);
            check("matrix_out_held", matrix_out, expo);
        end
    endtask

    initial begin
        logic [199:0] t;
        logic [199:0] x;
        bit seen;

        t = '0; t = put_row(t, 19, 10'h3FE); t = put_row(t, 18, 10'h001); t = put_row(t, 5, 10'h2AA);
        vecs[0] = '{m: t, lines: 3'd0, exp_out: t};
        t = '0; t = put_row(t, 19, 10'h3FF); t[183] = 1'b1;
        x = '0; x[193] = 1'b1;
        vecs[1] = '{m: t, lines: 3'd1, exp_out: x};
        t = '0; t = put_row(t, 16, 10'h3FF); t = put_row(t, 17, 10'h155);
        t = put_row(t, 18, 10'h3FF); t = put_row(t, 19, 10'h3FF);
        x = '0; x = put_row(x, 19, 10'h155);
        vecs[2] = '{m: t, lines: 3'd3, exp_out: x};
        t = '0; t = put_row(t, 17, 10'h3FF); t = put_row(t, 19, 10'h3FF); t = put_row(t, 18, 10'h0F0);
        t = put_row(t, 16, 10'h00F); t = put_row(t, 10, 10'h200);
        x = '0; x = put_row(x, 19, 10'h0F0); x = put_row(x, 18, 10'h00F); x = put_row(x, 12, 10'h200);
        vecs[3] = '{m: t, lines: 3'd2, exp_out: x};
        t = '0; t = put_row(t, 0, 10'h3FF); t = put_row(t, 5, 10'h3FF); t = put_row(t, 10, 10'h3FF);
        t = put_row(t, 19, 10'h3FF); t = put_row(t, 18, 10'h1FF); t = put_row(t, 6, 10'h111);
        x = '0; x = put_row(x, 19, 10'h1FF); x = put_row(x, 8, 10'h111);
        vecs[4] = '{m: t, lines: 3'd4, exp_out: x};

        clr = 1'b1; start = 1'b0; frame_start = 1'b0; matrix_in = vecs[2].m;
        step();
        step();
        check("rst_busy", {199'd0, busy}, '0);
        check("rst_done", {199'd0, done}, '0);
        check("rst_lines", {197'd0, lines_cleared}, '0);
        check("rst_out", matrix_out, '0);
        check("rst_disp", matrix_disp, '0);
        check("rst_flash", flash, '0);
        clr = 1'b0;

        step();
        step();
        check("idle_disp_hold", matrix_disp, '0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("idle_disp_frame", matrix_disp, vecs[2].m);
        matrix_in = vecs[3].m;
        step();
        check("idle_disp_midframe", matrix_disp, vecs[2].m);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("idle_disp_frame2", matrix_disp, vecs[3].m);

        for (int i = 0; i < 5; i++) begin
            run_pass(vecs[i].m, vecs[i].lines, vecs[i].exp_out, 1'b0);
        end

        run_pass(vecs[1].m, vecs[1].lines, vecs[1].exp_out, 1'b1);

        // Abort a pass once the rows are blinking.
        matrix_in = vecs[2].m;
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            frame_start = (c % FRAME_GAP == FRAME_GAP - 1);
            step();
            frame_start = 1'b0;
            if (flash != '0) seen = 1'b1;
        end
        check("flash_reached", {199'd0, seen}, 200'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("abort_flash", flash, '0);
        check("abort_disp", matrix_disp, '0);
        check("abort_busy", {199'd0, busy}, '0);
        check("abort_out", matrix_out, '0);

        run_pass(vecs[2].m, vecs[2].lines, vecs[2].exp_out, 1'b0);
        check("sb_empty", 200'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
